// File: rtl/mem_access_arbiter_pkg.sv
// Shared definitions for the IFU/LSU memory-port arbiter: FSM state encoding,
// requester ids and default bus widths.
package mem_access_arbiter_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 64;
    localparam int LAT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic MID_IFU = 1'b0;
    localparam logic MID_LSU = 1'b1;

endpackage

// File: rtl/mem_access_arbiter_rr.sv
// Two-way round-robin grant: a lone request always wins; on a tie the requester
// that did not win last time is granted.
module mem_access_arbiter_rr (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one single-cycle memory port between the IFU and the LSU, one transaction
// in flight, with a single-cycle chip-enable pulse per access.
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LATENCY = 0
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    input  logic                ifu_req_we,
    input  logic [DATA_W-1:0]   ifu_req_wdata,
    input  logic [DATA_W/8-1:0] ifu_req_wmask,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_resp_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_we,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_resp_rdata,

    output logic                mem_ce,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_W / 8;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                gnt_id_q, gnt_id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic [LAT_W-1:0]    cnt_q, cnt_d;

    logic [1:0]          req_vec;
    logic [1:0]          gnt;
    logic [1:0]          resp_valid_vec;
    logic [1:0]          resp_ready_vec;

    assign req_vec        = {lsu_req_valid, ifu_req_valid};
    assign resp_ready_vec = {lsu_resp_ready, ifu_resp_ready};

    mem_access_arbiter_rr u_rr (
        .req  (req_vec),
        .last (last_grant_q),
        .en   (state_q == ST_IDLE),
        .gnt  (gnt)
    );

    assign ifu_req_ready = gnt[MID_IFU];
    assign lsu_req_ready = gnt[MID_LSU];

    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        assign resp_valid_vec[gi] = (state_q == ST_RESP) && (gnt_id_q == 1'(gi));
    end

    assign ifu_resp_valid = resp_valid_vec[MID_IFU];
    assign lsu_resp_valid = resp_valid_vec[MID_LSU];
    assign ifu_resp_rdata = resp_valid_vec[MID_IFU] ? resp_data_q : '0;
    assign lsu_resp_rdata = resp_valid_vec[MID_LSU] ? resp_data_q : '0;

    // The memory port sees the captured request at all times; only ce/we qualify it.
    assign mem_ce    = (state_q == ST_ACCESS);
    assign mem_we    = mem_ce & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_id_d     = gnt_id_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        resp_data_d  = resp_data_q;
        cnt_d        = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    state_d      = ST_ACCESS;
                    gnt_id_d     = gnt[MID_LSU] ? MID_LSU : MID_IFU;
                    last_grant_d = gnt_id_d;
                    if (gnt[MID_LSU]) begin
                        addr_d  = lsu_req_addr;
                        we_d    = lsu_req_we;
                        wdata_d = lsu_req_wdata;
                        wmask_d = lsu_req_wmask;
                    end else begin
                        addr_d  = ifu_req_addr;
                        we_d    = ifu_req_we;
                        wdata_d = ifu_req_wdata;
                        wmask_d = ifu_req_wmask;
                    end
                end
            end
            ST_ACCESS: begin
                resp_data_d = we_q ? '0 : mem_rdata;
                if (LATENCY == 0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = LAT_W'(LATENCY);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= LAT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (|(resp_valid_vec & resp_ready_vec)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= MID_IFU;
            gnt_id_q     <= MID_IFU;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            resp_data_q  <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_id_q     <= gnt_id_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            resp_data_q  <= resp_data_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: one instance with no extra latency and one
// with three wait cycles, checked against a response scoreboard and a memory model.
module tb_mem_access_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [63:0] ifu_addr, lsu_addr, ifu_wdata, lsu_wdata;
    logic        ifu_we, lsu_we;
    logic [7:0]  ifu_wmask, lsu_wmask;

    logic        ifu_valid0, lsu_valid0, ifu_rr0, lsu_rr0;
    logic        ifu_rdy0, lsu_rdy0, ifu_rv0, lsu_rv0;
    logic [63:0] ifu_rd0, lsu_rd0;
    logic        mce0, mwe0;
    logic [63:0] maddr0, mwd0, mrd0;
    logic [7:0]  mwm0;

    logic        ifu_valid3, ifu_rr3, lsu_valid3, lsu_rr3;
    logic        ifu_rdy3, lsu_rdy3, ifu_rv3, lsu_rv3;
    logic [63:0] ifu_rd3, lsu_rd3;
    logic        mce3, mwe3;
    logic [63:0] maddr3, mwd3, mrd3;
    logic [7:0]  mwm3;

    function automatic logic [63:0] mem_model(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h0000_0413;
        return {a[31:0] ^ 32'h1357_9bdf, ~a[31:0]};
    endfunction

    assign mrd0 = mem_model(maddr0);
    assign mrd3 = mem_model(maddr3);

    mem_access_arbiter #(.ADDR_W(64), .DATA_W(64), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_valid0), .ifu_req_ready(ifu_rdy0), .ifu_req_addr(ifu_addr),
        .ifu_req_we(ifu_we), .ifu_req_wdata(ifu_wdata), .ifu_req_wmask(ifu_wmask),
        .ifu_resp_valid(ifu_rv0), .ifu_resp_ready(ifu_rr0), .ifu_resp_rdata(ifu_rd0),
        .lsu_req_valid(lsu_valid0), .lsu_req_ready(lsu_rdy0), .lsu_req_addr(lsu_addr),
        .lsu_req_we(lsu_we), .lsu_req_wdata(lsu_wdata), .lsu_req_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_rv0), .lsu_resp_ready(lsu_rr0), .lsu_resp_rdata(lsu_rd0),
        .mem_ce(mce0), .mem_we(mwe0), .mem_addr(maddr0), .mem_wdata(mwd0),
        .mem_wmask(mwm0), .mem_rdata(mrd0)
    );

    mem_access_arbiter #(.ADDR_W(64), .DATA_W(64), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_valid3), .ifu_req_ready(ifu_rdy3), .ifu_req_addr(ifu_addr),
        .ifu_req_we(ifu_we), .ifu_req_wdata(ifu_wdata), .ifu_req_wmask(ifu_wmask),
        .ifu_resp_valid(ifu_rv3), .ifu_resp_ready(ifu_rr3), .ifu_resp_rdata(ifu_rd3),
        .lsu_req_valid(lsu_valid3), .lsu_req_ready(lsu_rdy3), .lsu_req_addr(lsu_addr),
        .lsu_req_we(lsu_we), .lsu_req_wdata(lsu_wdata), .lsu_req_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_rv3), .lsu_resp_ready(lsu_rr3), .lsu_resp_rdata(lsu_rd3),
        .mem_ce(mce3), .mem_we(mwe3), .mem_addr(maddr3), .mem_wdata(mwd3),
        .mem_wmask(mwm3), .mem_rdata(mrd3)
    );

    // Access monitor: count chip-enable pulses and remember the last access on dut0.
    int          ce0 = 0;
    int          ce3 = 0;
    logic        last_we0 = 1'b0;
    logic [63:0] last_addr0 = '0;
    logic [63:0] last_wd0 = '0;
    logic [7:0]  last_wm0 = '0;
    always @(posedge clk) begin
        if (mce0 === 1'b1) begin
            ce0++;
            last_we0   = mwe0;
            last_addr0 = maddr0;
            last_wd0   = mwd0;
            last_wm0   = mwm0;
        end
        if (mce3 === 1'b1) ce3++;
    end

    typedef struct packed {
        logic        id;
        logic [63:0] rdata;
    } exp_t;
    exp_t sb[$];
    exp_t cur;

    int total = 0;
    int bad   = 0;
    int n_lat;
    int ce_snap;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit d3, input bit id);
        if (d3) return id ? lsu_rdy3 : ifu_rdy3;
        return id ? lsu_rdy0 : ifu_rdy0;
    endfunction

    function automatic logic rv(input bit d3, input bit id);
        if (d3) return id ? lsu_rv3 : ifu_rv3;
        return id ? lsu_rv0 : ifu_rv0;
    endfunction

    function automatic logic [63:0] rdat(input bit d3, input bit id);
        if (d3) return id ? lsu_rd3 : ifu_rd3;
        return id ? lsu_rd0 : ifu_rd0;
    endfunction

    function automatic int cecount(input bit d3);
        return d3 ? ce3 : ce0;
    endfunction

    task automatic set_valid(input bit d3, input bit id, input logic v);
        if (d3) ifu_valid3 = v;
        else if (id) lsu_valid0 = v;
        else ifu_valid0 = v;
    endtask

    task automatic set_rr(input bit d3, input bit id, input logic v);
        if (d3) ifu_rr3 = v;
        else if (id) lsu_rr0 = v;
        else ifu_rr0 = v;
    endtask

    // Called just after a negedge with the request(s) already driven.
    task automatic accept(input bit d3, input bit exp_id, input string tag);
        int   k;
        exp_t e;
        logic we;
        logic [63:0] a;
        k = 0;
        #1;
        while (!rdy(d3, 1'b0) && !rdy(d3, 1'b1) && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        if (k >= 20) begin
            check({tag, " accept_timeout"}, 64'd0, 64'd1);
            return;
        end
        check({tag, " grant"}, {63'd0, rdy(d3, exp_id)}, 64'd1);
        check({tag, " other_ready"}, {63'd0, rdy(d3, !exp_id)}, 64'd0);
        we = exp_id ? lsu_we : ifu_we;
        a  = exp_id ? lsu_addr : ifu_addr;
        e.id    = exp_id;
        e.rdata = we ? 64'd0 : mem_model(a);
        sb.push_back(e);
        ce_snap = cecount(d3);
        @(negedge clk);
        set_valid(d3, exp_id, 1'b0);
        n_lat = 1;
    endtask

    task automatic await_resp(input bit d3, input int exp_lat, input string tag);
        #1;
        if (sb.size() == 0) begin
            check({tag, " scoreboard_empty"}, 64'd0, 64'd1);
            return;
        end
        cur = sb.pop_front();
        while (!rv(d3, cur.id) && n_lat < 40) begin
            @(negedge clk); #1;
            n_lat++;
        end
        check({tag, " latency"}, 64'(n_lat), 64'(exp_lat));
        check({tag, " resp_valid"}, {63'd0, rv(d3, cur.id)}, 64'd1);
        check({tag, " rdata"}, rdat(d3, cur.id), cur.rdata);
        check({tag, " other_resp_valid"}, {63'd0, rv(d3, !cur.id)}, 64'd0);
        $display("txn %s dut_lat=%0d id=%0d lat=%0d rdata=%h", tag, d3 ? 3 : 0, cur.id, n_lat,
                 rdat(d3, cur.id));
    endtask

    task automatic consume(input bit d3, input string tag);
        set_rr(d3, cur.id, 1'b1);
        @(negedge clk);
        set_rr(d3, cur.id, 1'b0);
        #1;
        check({tag, " resp_drop"}, {63'd0, rv(d3, cur.id)}, 64'd0);
        check({tag, " ce_pulses"}, 64'(cecount(d3) - ce_snap), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ifu_valid0 = 0; lsu_valid0 = 0; ifu_rr0 = 0; lsu_rr0 = 0;
        ifu_valid3 = 0; lsu_valid3 = 0; ifu_rr3 = 0; lsu_rr3 = 0;
        ifu_addr = '0; lsu_addr = '0; ifu_wdata = '0; lsu_wdata = '0;
        ifu_we = 0; lsu_we = 0; ifu_wmask = '0; lsu_wmask = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset ifu_ready", {63'd0, ifu_rdy0}, 64'd0);
        check("reset resp_valid", {62'd0, ifu_rv0, lsu_rv0}, 64'd0);
        check("reset mem_ce_we", {62'd0, mce0, mwe0}, 64'd0);
        check("reset mem_addr", maddr0, 64'd0);
        check("reset mem_wdata", mwd0, 64'd0);
        check("reset mem_wmask", {56'd0, mwm0}, 64'd0);
        check("reset rdata", ifu_rd0 | lsu_rd0, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Ties: LSU first after reset, then alternate.
        ifu_addr = 64'h8000_0040; ifu_we = 0; ifu_valid0 = 1;
        lsu_addr = 64'h8000_2000; lsu_we = 0; lsu_valid0 = 1;
        accept(0, 1, "tie1_lsu"); await_resp(0, 2, "tie1_lsu"); consume(0, "tie1_lsu");
        lsu_addr = 64'h8000_2008; lsu_valid0 = 1;
        accept(0, 0, "tie2_ifu"); await_resp(0, 2, "tie2_ifu"); consume(0, "tie2_ifu");
        ifu_addr = 64'h8000_0048; ifu_valid0 = 1;
        accept(0, 1, "tie3_lsu"); await_resp(0, 2, "tie3_lsu"); consume(0, "tie3_lsu");
        accept(0, 0, "tie4_ifu"); await_resp(0, 2, "tie4_ifu"); consume(0, "tie4_ifu");

        // IFU read of the reset vector.
        @(negedge clk);
        ifu_addr = 64'h8000_0000; ifu_we = 0; ifu_valid0 = 1;
        accept(0, 0, "ifu_read"); await_resp(0, 2, "ifu_read");
        check("ifu_read const", ifu_rd0, 64'h0000_0413);
        consume(0, "ifu_read");

        // LSU partial write returns zero data.
        @(negedge clk);
        lsu_addr = 64'h8000_1000; lsu_we = 1; lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
        lsu_valid0 = 1;
        accept(0, 1, "lsu_write"); await_resp(0, 2, "lsu_write");
        check("lsu_write rdata", lsu_rd0, 64'd0);
        consume(0, "lsu_write");
        check("lsu_write mem_we", {63'd0, last_we0}, 64'd1);
        check("lsu_write mem_addr", last_addr0, 64'h8000_1000);
        check("lsu_write mem_wdata", last_wd0, 64'hDEAD_BEEF);
        check("lsu_write mem_wmask", {56'd0, last_wm0}, 64'h0F);
        lsu_we = 0;

        // Held response blocks everyone.
        @(negedge clk);
        ifu_addr = 64'h8000_0008; ifu_valid0 = 1;
        accept(0, 0, "hold"); await_resp(0, 2, "hold");
        lsu_addr = 64'h8000_3000; lsu_valid0 = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check("hold resp_valid", {63'd0, ifu_rv0}, 64'd1);
            check("hold rdata", ifu_rd0, cur.rdata);
            check("hold ready", {62'd0, ifu_rdy0, lsu_rdy0}, 64'd0);
            check("hold ce", 64'(ce0 - ce_snap), 64'd1);
        end
        consume(0, "hold");
        accept(0, 1, "after_hold"); await_resp(0, 2, "after_hold"); consume(0, "after_hold");

        // Three wait cycles.
        @(negedge clk);
        ifu_addr = 64'h8000_0100; ifu_valid3 = 1;
        accept(1, 0, "lat3"); await_resp(1, 5, "lat3"); consume(1, "lat3");

        // Reset during WAIT aborts the transaction.
        @(negedge clk);
        ifu_addr = 64'h8000_0200; ifu_valid3 = 1;
        accept(1, 0, "abort");
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort resp_valid", {63'd0, ifu_rv3}, 64'd0);
        check("abort mem_ce_we", {62'd0, mce3, mwe3}, 64'd0);
        check("abort mem_addr", maddr3, 64'd0);
        check("abort rdata", ifu_rd3, 64'd0);
        void'(sb.pop_front());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            check("abort no_resp", {63'd0, ifu_rv3}, 64'd0);
        end
        check("abort ce_pulses", 64'(ce3 - ce_snap), 64'd1);
        @(negedge clk);
        ifu_addr = 64'h8000_0300; ifu_valid3 = 1;
        accept(1, 0, "post_abort"); await_resp(1, 5, "post_abort"); consume(1, "post_abort");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
